// File: rtl/reg64_pkg.sv
// Shared definitions for the reg64_rr_arbiter block.
//   WIDTH_DEF   default data width of each requester and of the holding register
//   N_REQ_DEF   default number of requesters
//   arb_state_e lock FSM states (used only when ARB_LOCK_EN is defined)
package reg64_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int N_REQ_DEF = 4;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Scans requesters ptr+1, ptr+2, ... (modulo N_REQ) and returns the first one
// that is both requesting and unmasked.
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  IW     index of the last winner (lowest priority this cycle)
//   mask   in  N_REQ  1 = requester may win
//   onehot out N_REQ  one-hot winner, 0 when nobody eligible
//   index  out IW     winner index, 0 when nobody eligible
module rr_priority_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    index
);

  logic [N_REQ-1:0] cand;

  assign cand = req & mask;

  // Walk from the farthest position back to ptr+1 so the closest eligible
  // requester is the last (and therefore surviving) assignment.
  always_comb begin
    int          k;
    logic [IW-1:0] kk;
    onehot = '0;
    index  = '0;
    k      = 0;
    kk     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      kk = IW'(k);
      if (cand[kk]) begin
        onehot     = '0;
        onehot[kk] = 1'b1;
        index      = kk;
      end
    end
  end

endmodule

// File: rtl/reg64_rr_arbiter.sv
// Round-robin arbitrated 64-bit holding register.
// N_REQ writers compete for one register; the winner of each cycle is acked by
// a combinational one-hot grant and its data is captured at the next rising edge.
// Optional feature macro: ARB_LOCK_EN -- lets a winner holding lock[] keep the
// register for up to MAX_LOCK consecutive captures. Without it, lock is ignored
// and arbitration is pure round-robin.
// Ports:
//   clk     in  1              rising-edge clock
//   rst     in  1              asynchronous reset, active-high
//   req     in  N_REQ          request per requester, held until granted
//   data    in  N_REQ*WIDTH    requester i data at [i*WIDTH +: WIDTH]
//   lock    in  N_REQ          keep-grant request (ARB_LOCK_EN builds only)
//   grant   out N_REQ          one-hot ack, forced to 0 during reset
//   q       out WIDTH          captured data
//   q_valid out 1              pulses for one cycle after each capture
//   q_src   out $clog2(N_REQ)  index of the requester whose data is in q
module reg64_rr_arbiter
  import reg64_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_LOCK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         grant,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [$clog2(N_REQ)-1:0] q_src
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [N_REQ-1:0] mask;
  logic             win_any;
  logic             release_now;

  rr_priority_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .mask   (mask),
    .onehot (win_onehot),
    .index  (win_idx)
  );

  assign win_any = |win_onehot;
  assign grant   = rst ? '0 : win_onehot;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e    state;
  arb_state_e    state_next;
  logic [IW-1:0] owner;
  logic [IW-1:0] owner_next;
  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] lock_cnt_next;

  // While locked only the owner is eligible.
  always_comb begin
    mask = '1;
    if (state == ARB_LOCKED) begin
      mask        = '0;
      mask[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    owner_next    = owner;
    lock_cnt_next = lock_cnt;
    release_now   = 1'b0;
    case (state)
      ARB_IDLE: begin
        // A one-capture limit is already exhausted by the entering capture,
        // so the lock is never taken in that case.
        if (win_any && lock[win_idx] && (MAX_LOCK > 1)) begin
          state_next    = ARB_LOCKED;
          owner_next    = win_idx;
          lock_cnt_next = CW'(1);
        end
      end
      ARB_LOCKED: begin
        if (win_any) lock_cnt_next = lock_cnt + CW'(1);
        if (!req[owner] || !lock[owner] ||
            (win_any && (int'(lock_cnt) + 1 >= MAX_LOCK))) begin
          state_next    = ARB_IDLE;
          lock_cnt_next = '0;
          release_now   = 1'b1;
        end
      end
      default: begin
        state_next    = ARB_IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      owner    <= owner_next;
      lock_cnt <= lock_cnt_next;
    end
  end
`else
  localparam int LOCK_LIMIT_UNUSED = MAX_LOCK;
  logic lock_unused;

  assign lock_unused = ^lock;
  assign mask        = '1;
  assign release_now = 1'b0;
`endif

  // A release without a capture still parks the pointer on the old owner so
  // it has lowest priority on the following cycle.
  always_comb begin
    ptr_next = ptr;
    if (win_any) ptr_next = win_idx;
`ifdef ARB_LOCK_EN
    else if (release_now) ptr_next = owner;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= IW'(N_REQ - 1);
    else     ptr <= ptr_next;
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      q_src   <= '0;
    end else begin
      q_valid <= win_any;
      if (win_any) begin
        q     <= data[win_idx*WIDTH +: WIDTH];
        q_src <= win_idx;
      end
    end
  end

endmodule
